// File: rtl/tqvp_crc32_arbiter_if.sv
// Request/response bundle between the per-channel register front-ends and the shared CRC engine.
interface tqvp_crc32_arbiter_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_clear;
    logic [8*NUM_CH-1:0]  req_data;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH-1:0]    done;
    logic                 busy;
    logic [32*NUM_CH-1:0] crc_out;

    modport master (
        output req_valid, req_clear, req_data,
        input  req_ready, done, busy, crc_out
    );

    modport slave (
        input  req_valid, req_clear, req_data,
        output req_ready, done, busy, crc_out
    );
endinterface

// File: rtl/tqvp_crc32_arbiter.sv
// One bit-serial reflected CRC-32 engine shared round-robin between NUM_CH channels,
// each with its own running-CRC context.
//   state | meaning
//   IDLE  | arbitrate; accept a clear (stays here) or a byte (goes to SHIFT)
//   SHIFT | shift the owner's byte one bit per clock, write back after 8 bits
module tqvp_crc32_arbiter #(
    parameter int          NUM_CH = 2,
    parameter logic [31:0] POLY   = 32'hEDB88320,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input logic                  clk,
    input logic                  rst,
    tqvp_crc32_arbiter_if.slave  bus
);
    localparam int              PW   = (NUM_CH > 2) ? 2 : 1;
    localparam logic [PW-1:0]   LAST = PW'(NUM_CH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rr_ptr, owner, winner;
    logic              found, accept;
    logic [2:0]        bit_cnt;
    logic [31:0]       sh, sh_nxt;
    logic [31:0]       ctx [NUM_CH];
    logic [7:0]        data_ch [NUM_CH];
    logic [NUM_CH-1:0] ready, done_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign data_ch[i]               = bus.req_data[8*i +: 8];
        assign bus.crc_out[32*i +: 32]  = ctx[i] ^ XOROUT;
    end

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        logic [PW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_CH);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign sh_nxt = sh[0] ? ((sh >> 1) ^ POLY) : (sh >> 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (found && !rst) begin
                    ready[winner] = 1'b1;
                    accept        = 1'b1;
                    if (!bus.req_clear[winner]) state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == 3'd7) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ctx[i] <= INIT;
            rr_ptr  <= LAST;
            owner   <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            if (accept) begin
                rr_ptr <= winner;
                if (bus.req_clear[winner]) begin
                    ctx[winner]    <= INIT;
                    done_q[winner] <= 1'b1;
                end else begin
                    sh      <= ctx[winner] ^ {24'h0, data_ch[winner]};
                    owner   <= winner;
                    bit_cnt <= '0;
                end
            end else if (state == SHIFT) begin
                sh      <= sh_nxt;
                bit_cnt <= bit_cnt + 3'd1;
                // Context is written only once the whole byte is folded in.
                if (bit_cnt == 3'd7) begin
                    ctx[owner]    <= sh_nxt;
                    done_q[owner] <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.done      = done_q;
    assign bus.busy      = (state == SHIFT);
endmodule

// File: tb/tb_tqvp_crc32_arbiter.sv
// Randomized scoreboard bench for the shared CRC-32 arbiter: a driver feeds per-channel
// request lists, a monitor checks each done pulse, arbitration and busy against a reference.
module tb_tqvp_crc32_arbiter;
    localparam int          NUM_CH = 2;
    localparam logic [31:0] POLY   = 32'hEDB88320;
    localparam logic [31:0] INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] XOROUT = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tqvp_crc32_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    tqvp_crc32_arbiter #(
        .NUM_CH(NUM_CH), .POLY(POLY), .INIT(INIT), .XOROUT(XOROUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] crc;
        int          lat;
    } exp_t;

    exp_t        exp_q   [NUM_CH][$];
    logic [8:0]  items   [NUM_CH][$];
    logic [31:0] ctx_m   [NUM_CH];
    int          acc_cyc [NUM_CH];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: reflected CRC-32, one byte folded into a running register.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_of(input int i);
        return bus.crc_out[32*i +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic present(input int i, input logic [8:0] it);
        exp_t e;
        bus.req_valid[i]       = 1'b1;
        bus.req_clear[i]       = it[8];
        bus.req_data[8*i +: 8] = it[7:0];
        if (it[8]) begin
            ctx_m[i] = INIT;
            e.lat    = 1;
        end else begin
            ctx_m[i] = crc_byte(ctx_m[i], it[7:0]);
            e.lat    = 9;
        end
        e.crc = ctx_m[i] ^ XOROUT;
        exp_q[i].push_back(e);
    endtask

    task automatic load_str(input int i, input string s);
        for (int j = 0; j < s.len(); j++) items[i].push_back({1'b0, s[j]});
    endtask

    function automatic bit pending();
        bit p;
        p = (bus.req_valid != '0);
        for (int i = 0; i < NUM_CH; i++)
            if (items[i].size() != 0 || exp_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_phase(input int max_gap, input int delay0, input int delay1);
        int gap [NUM_CH];
        bit acc [NUM_CH];
        int budget;
        gap[0] = delay0;
        gap[1] = delay1;
        for (int i = 0; i < NUM_CH; i++) acc[i] = 1'b0;
        budget = 0;
        while (pending() && budget < 5000) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[i]) begin
                    bus.req_valid[i] = 1'b0;
                    acc[i]           = 1'b0;
                    gap[i]           = $urandom_range(0, max_gap);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!bus.req_valid[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else if (items[i].size() != 0) present(i, items[i].pop_front());
                end
            end
            #1;
            for (int i = 0; i < NUM_CH; i++) acc[i] = bus.req_valid[i] && bus.req_ready[i];
        end
        if (budget >= 5000) begin
            checks++;
            failures++;
            $display("FAIL phase_timeout actual=%0d required=<5000 cycles", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        for (int i = 0; i < NUM_CH; i++) ctx_m[i] = INIT;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: scoreboard pops on done, plus round-robin and busy reference.
    initial begin
        logic [31:0]       prev_crc [NUM_CH];
        logic [NUM_CH-1:0] exp_r;
        bit                prev_rst;
        bit                busy_m;
        int                sh_cnt;
        int                last_g;
        int                c;
        exp_t              e;
        sh_cnt   = 0;
        last_g   = NUM_CH - 1;
        prev_rst = 1'b1;
        for (int i = 0; i < NUM_CH; i++) prev_crc[i] = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    exp_q[i].delete();
                    prev_crc[i] = crc_of(i);
                end
                sh_cnt   = 0;
                last_g   = NUM_CH - 1;
                prev_rst = 1'b1;
                continue;
            end
            busy_m = (sh_cnt > 0);
            check("busy", 32'(bus.busy), 32'(busy_m));
            if (sh_cnt > 0) sh_cnt--;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.done[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_unexpected ch%0d actual=1 required=0 cycle=%0d", i, cyc);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("crc_out_ch%0d", i), crc_of(i), e.crc);
                        check($sformatf("done_latency_ch%0d", i), 32'(cyc - acc_cyc[i]), 32'(e.lat));
                    end
                end else if (!prev_rst && crc_of(i) !== prev_crc[i]) begin
                    checks++;
                    failures++;
                    $display("FAIL crc_changed_without_done ch%0d actual=%h required=%h", i, crc_of(i), prev_crc[i]);
                end
                prev_crc[i] = crc_of(i);
            end
            prev_rst = 1'b0;
            exp_r = '0;
            if (!busy_m) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (last_g + k) % NUM_CH;
                    if (exp_r == '0 && bus.req_valid[c]) exp_r[c] = 1'b1;
                end
            end
            check("req_ready", 32'(bus.req_ready), 32'(exp_r));
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    acc_cyc[i] = cyc;
                    last_g     = i;
                    if (!bus.req_clear[i]) sh_cnt = 8;
                end
            end
        end
    end

    initial begin
        logic       rc;
        logic [7:0] rd;
        bus.req_valid = '0;
        bus.req_clear = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ctx_m[i]   = INIT;
            acc_cyc[i] = 0;
        end

        // Reset: ready suppressed even with a valid request, then reset values.
        bus.req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("ready_in_reset", 32'(bus.req_ready), 32'h0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("reset_crc0", crc_of(0), 32'h0);
        check("reset_crc1", crc_of(1), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);

        // Single stream, back to back.
        load_str(0, "123456789");
        run_phase(0, 0, 0);
        check("check_value_ch0", crc_of(0), 32'hCBF43926);
        check("idle_ch1", crc_of(1), 32'h0);

        // Both channels continuously valid.
        do_reset();
        for (int j = 0; j < 6; j++) begin
            items[0].push_back({1'b0, 8'($urandom)});
            items[1].push_back({1'b0, 8'($urandom)});
        end
        run_phase(0, 0, 0);

        // Interleaved streams.
        do_reset();
        load_str(0, "123456789");
        load_str(1, "abc");
        run_phase(0, 0, 0);
        check("interleave_ch0", crc_of(0), 32'hCBF43926);
        check("interleave_ch1", crc_of(1), 32'h352441C2);

        // Clear on ch0 raised while ch1 is shifting.
        load_str(1, "d");
        items[0].push_back(9'h100);
        run_phase(0, 3, 0);
        check("clear_while_busy_ch0", crc_of(0), 32'h0);
        check("ch1_after_clear_ch0", crc_of(1), crc_byte(crc_byte(crc_byte(crc_byte(INIT, "a"), "b"), "c"), "d") ^ XOROUT);

        // Single zero byte, then clear.
        do_reset();
        items[1].push_back(9'h000);
        run_phase(0, 0, 0);
        check("zero_byte_ch1", crc_of(1), 32'hD202EF8D);
        items[1].push_back(9'h100);
        run_phase(0, 0, 0);
        check("cleared_ch1", crc_of(1), 32'h0);

        // Reset in the middle of a byte (bit_cnt==4).
        do_reset();
        @(negedge clk);
        present(0, {1'b0, 8'h31});
        #1;
        check("ready_ch0_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst      = 1'b1;
        ctx_m[0] = INIT;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("midreset_busy", 32'(bus.busy), 32'h0);
        check("midreset_crc0", crc_of(0), 32'h0);
        check("midreset_done", 32'(bus.done), 32'h0);
        repeat (12) @(negedge clk);
        load_str(0, "123456789");
        run_phase(0, 0, 0);
        check("after_midreset_ch0", crc_of(0), 32'hCBF43926);

        // Random traffic with clears and gaps.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < 30; j++) begin
                rc = ($urandom_range(0, 7) == 0);
                rd = 8'($urandom);
                items[i].push_back({rc, rd});
            end
        end
        run_phase(3, $urandom_range(0, 4), $urandom_range(0, 4));
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("random_final_ch%0d", i), crc_of(i), ctx_m[i] ^ XOROUT);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
